// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, LFSR polynomial and BIST FSM states shared by the ALU BIST blocks
package alu_pkg;
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOR = 2'd3;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
endpackage

// File: rtl/lfsr32.sv
// lfsr32: 32-bit right-shifting Galois LFSR with seed load and step enable
module lfsr32
  import alu_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEED;
    else if (load) q <= SEED;
    else if (step) q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
endmodule

// File: rtl/logic_bist.sv
// logic_bist: LFSR-driven self-test of the ALU bitwise units with golden compare and error capture
module logic_bist
  import alu_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED_A      = 32'hF114002A,
  parameter logic [31:0] SEED_B      = 32'hDBB44050
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] first,
  output logic [WIDTH-1:0] second,
  output logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       fail_index
);
  state_t state, state_nx;
  logic [7:0] vec;
  logic [1:0] op;
  logic [31:0] lfsr_a, lfsr_b;
  logic [WIDTH-1:0] golden;
  logic go, last_op, last_vec, mismatch;
  assign go       = start && (state == IDLE || state == DONE);
  assign last_op  = op == OP_NOR;
  assign last_vec = vec == 8'(NUM_VECTORS - 1);
  assign op_sel   = op;
  // operands read as zero outside a run so reset/idle outputs are all-zero
  assign first  = busy ? WIDTH'(lfsr_a) : '0;
  assign second = busy ? WIDTH'(lfsr_b) : '0;
  assign golden = op == OP_AND ? first & second :
                  op == OP_OR  ? first | second :
                  op == OP_XOR ? first ^ second : ~(first | second);
  assign mismatch = state == CHECK && result != golden;
  lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
    .clk(clk), .rst_n(rst_n), .load(go),
    .step(state == CHECK && last_op && !last_vec), .q(lfsr_a)
  );
  lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
    .clk(clk), .rst_n(rst_n), .load(go),
    .step(state == CHECK && last_op && !last_vec), .q(lfsr_b)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    busy     = state == DRIVE || state == CHECK;
    done     = state == DONE;
    pass     = state == DONE && err_count == 8'd0;
    case (state)
      IDLE, DONE: state_nx = go ? DRIVE : state;
      DRIVE:      state_nx = CHECK;
      default:    state_nx = last_op && last_vec ? DONE : DRIVE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec        <= '0;
      op         <= '0;
      err_count  <= '0;
      fail_index <= 8'hFF;
    end else if (go) begin
      vec        <= '0;
      op         <= '0;
      err_count  <= '0;
      fail_index <= 8'hFF;
    end else if (state == CHECK) begin
      op <= op + 2'd1;
      if (last_op && !last_vec) vec <= vec + 8'd1;
      if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
      // a zero count means this is the first mismatch of the run
      if (mismatch && err_count == 8'd0) fail_index <= {vec[5:0], op};
    end
endmodule

// File: tb/tb_logic_bist.sv
// tb_logic_bist: table-driven and randomized checks of logic_bist against a behavioural model
module tb_logic_bist;
  localparam int NV = 255;
  localparam logic [31:0] SA = 32'hF114002A;
  localparam logic [31:0] SB = 32'hDBB44050;
  localparam logic [31:0] POLY = 32'h80200003;

  typedef struct {
    int          m;
    logic [31:0] k;
    bit          mid;
    logic [7:0]  exp_err;
    logic [7:0]  exp_fi;
    logic        exp_pass;
  } rec_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0;
  logic [31:0] first, second, result, first1, second1, result1;
  logic [1:0] op_sel, op_sel1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [7:0] err_count, fail_index, err1, fi1;
  int mode = 0;
  logic [31:0] key = 32'h0;
  logic [31:0] ea [NV];
  logic [31:0] eb [NV];
  rec_t tbl [6];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] gold(input logic [31:0] x, y, input logic [1:0] o);
    case (o)
      2'd0: return x & y;
      2'd1: return x | y;
      2'd2: return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic logic [31:0] uut(input logic [31:0] x, y, input logic [1:0] o,
                                      input int m, input logic [31:0] k);
    logic [31:0] g;
    g = gold(x, y, o);
    case (m)
      0: return g;
      1: return g & ~32'h1;
      2: return ~g;
      default: return (((x ^ k) + {30'b0, o}) & 32'h7) == 0 ? g ^ (32'h1 << k[4:0]) : g;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ POLY;
    return y;
  endfunction

  assign result  = uut(first, second, op_sel, mode, key);
  assign result1 = gold(first1, second1, op_sel1);

  logic_bist #(.WIDTH(32), .NUM_VECTORS(NV), .SEED_A(SA), .SEED_B(SB)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first(first), .second(second),
    .op_sel(op_sel), .result(result), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_index(fail_index)
  );

  logic_bist #(.WIDTH(32), .NUM_VECTORS(1), .SEED_A(SA), .SEED_B(SB)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .first(first1), .second(second1),
    .op_sel(op_sel1), .result(result1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_index(fi1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_run(inout rec_t t);
    int cnt;
    logic [7:0] vv;
    logic [31:0] g;
    cnt = 0;
    t.exp_fi = 8'hFF;
    for (int v = 0; v < NV; v++)
      for (int o = 0; o < 4; o++) begin
        g = gold(ea[v], eb[v], 2'(o));
        if (uut(ea[v], eb[v], 2'(o), t.m, t.k) != g) begin
          vv = 8'(v);
          if (cnt == 0) t.exp_fi = {vv[5:0], 2'(o)};
          cnt++;
        end
      end
    t.exp_err  = cnt > 255 ? 8'd255 : 8'(cnt);
    t.exp_pass = cnt == 0;
  endtask

  task automatic run(input rec_t t);
    int bad, idx, v;
    logic [1:0] o;
    mode = t.m;
    key  = t.k;
    bad  = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int c = 1; c <= 8 * NV; c++) begin
      @(negedge clk);
      idx = (c - 1) / 2;
      v   = idx / 4;
      o   = 2'(idx % 4);
      if (!busy || done || first !== ea[v] || second !== eb[v] || op_sel !== o || first == 0 || second == 0)
        bad++;
      if (t.mid && c == 37) start = 1'b1;
      if (c == 38) start = 1'b0;
    end
    chk($sformatf("seq_m%0d", t.m), 32'(bad), 32'd0);
    @(negedge clk);
    chk("done", {31'b0, done}, 32'd1);
    chk("busy_fall", {31'b0, busy}, 32'd0);
    chk($sformatf("err_m%0d", t.m), {24'b0, err_count}, {24'b0, t.exp_err});
    chk($sformatf("fi_m%0d", t.m), {24'b0, fail_index}, {24'b0, t.exp_fi});
    chk($sformatf("pass_m%0d", t.m), {31'b0, pass}, {31'b0, t.exp_pass});
    repeat (3) @(negedge clk);
    chk("done_hold", {31'b0, done}, 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_first"}, first, 32'h0);
    chk({tag, "_second"}, second, 32'h0);
    chk({tag, "_op"}, {30'b0, op_sel}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h0);
    chk({tag, "_pass"}, {31'b0, pass}, 32'h0);
    chk({tag, "_err"}, {24'b0, err_count}, 32'h0);
    chk({tag, "_fi"}, {24'b0, fail_index}, 32'hFF);
  endtask

  initial begin
    ea[0] = SA;
    eb[0] = SB;
    for (int v = 1; v < NV; v++) begin
      ea[v] = lfsr_next(ea[v-1]);
      eb[v] = lfsr_next(eb[v-1]);
    end
    tbl[0] = '{0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0};
    tbl[1] = '{1, 32'h0, 1'b1, 8'h0, 8'h0, 1'b0};
    tbl[2] = '{2, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0};
    tbl[3] = '{3, $urandom, 1'b0, 8'h0, 8'h0, 1'b0};
    tbl[4] = '{3, $urandom, 1'b1, 8'h0, 8'h0, 1'b0};
    tbl[5] = '{0, 32'h0, 1'b1, 8'h0, 8'h0, 1'b0};
    for (int i = 0; i < 6; i++) expect_run(tbl[i]);

    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;

    @(negedge clk) start1 = 1'b1;
    @(posedge clk) #1 start1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("one_a", first1, SA);
      chk("one_b", second1, SB);
      chk("one_op", {30'b0, op_sel1}, 32'((c - 1) / 2));
      chk("one_busy", {31'b0, busy1, done1}, 32'd2);
    end
    @(negedge clk);
    chk("one_done", {29'b0, busy1, done1, pass1}, 32'd3);
    chk("one_err", {24'b0, err1}, 32'h0);
    chk("one_fi", {24'b0, fi1}, 32'hFF);

    for (int i = 0; i < 5; i++) run(tbl[i]);

    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_state("abort");
    @(negedge clk) rst_n = 1'b1;
    run(tbl[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end want end of test");
    $fatal(1, "timeout");
  end
endmodule
